fetch_queue: RTL

//  Elastic instruction queue between fetch (writer) and decode (reader) in the BRISC-V pipeline.

---
 rtl/brisc_pkg.sv | 14 +
 rtl/fetch_queue_entry.sv | 23 ++
 rtl/fetch_queue.sv | 94 +++++++++
 3 files changed

// File: rtl/brisc_pkg.sv
// Shared BRISC-V front-end types and constants used by the fetch/decode boundary.
package brisc_pkg;

  localparam int XLEN = 32;

  // Canonical RISC-V NOP (addi x0, x0, 0).
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_entry.sv
// One fetch-queue slot: a {pc, instr} register with write enable, cleared on reset.
module fetch_queue_entry #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_we,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_q <= '0;
    else if (i_we)
      r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_queue.sv
// Elastic fetch-to-decode instruction queue: DEPTH-entry circular FIFO of {pc, instr}
// with valid/ready on both sides and a synchronous flush for redirects.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int XLEN  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_instr,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  import brisc_pkg::*;

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [PTR_W:0]      r_count;

  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic [DEPTH-1:0]    w_we;
  logic [2*XLEN-1:0]   w_slot [DEPTH];
  logic [2*XLEN-1:0]   w_head;

  // Status is decoded from registered count only, so neither handshake
  // output ever depends combinationally on the opposite side.
  assign w_full   = (r_count == CNT_FULL);
  assign w_empty  = (r_count == '0);
  assign in_ready = ~w_full;
  assign out_valid = ~w_empty;
  assign full     = w_full;
  assign empty    = w_empty;
  assign count    = r_count;

  assign w_push = in_valid & ~w_full & ~flush;
  assign w_pop  = ~w_empty & out_ready & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    assign w_we[gi] = w_push & (r_wr_ptr == PTR_W'(gi));

    fetch_queue_entry #(
      .W (2*XLEN)
    ) u_entry (
      .clk  (clk),
      .rst  (rst),
      .i_we (w_we[gi]),
      .i_d  ({in_pc, in_instr}),
      .o_q  (w_slot[gi])
    );
  end

  // Head read is a plain mux of registered storage: stale but deterministic when empty.
  assign w_head    = w_slot[r_rd_ptr];
  assign out_pc    = w_head[2*XLEN-1:XLEN];
  assign out_instr = w_head[XLEN-1:0];

endmodule
